// File: rtl/nor_chain_stimulus_gen_pkg.sv
// Shared types and LFSR constants for the NOR-chain stimulus generator.
// The LFSR step helper is used only when NOR_STIM_LFSR_EN is defined.
package nor_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } stim_state_t;

    localparam int              LFSR_W            = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Galois, right shift: feedback taps applied when the bit shifted out is 1.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        lfsr_step = (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/nor_stim_lfsr.sv
// 16-bit Galois LFSR for randomised segment lengths.
// load seeds it and steps once in the same edge, so the first length is already a fresh value.
module nor_stim_lfsr
    import nor_stim_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state,
    output logic [LFSR_W-1:0] state_nxt
);

    logic [LFSR_W-1:0] seed_eff;

    // An all-zero seed would lock the register, so substitute the default.
    assign seed_eff  = (seed == '0) ? LFSR_DEFAULT_SEED : seed;
    assign state_nxt = lfsr_step(load ? seed_eff : state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LFSR_DEFAULT_SEED;
        end else if (load || advance) begin
            state <= state_nxt;
        end
    end

endmodule

// File: rtl/nor_chain_stimulus_gen.sv
// Pulse-train generator driving the shared myin input of the NOR fanout netlists.
// Define NOR_STIM_LFSR_EN to build in LFSR-randomised segment lengths (cfg_random/cfg_seed).
module nor_chain_stimulus_gen
    import nor_stim_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int NUM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_low_len,
    input  logic [CNT_W-1:0] cfg_high_len,
    input  logic [NUM_W-1:0] cfg_num,
    input  logic             cfg_random,
    input  logic [15:0]      cfg_seed,
    output logic             stim_out,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_cnt
);

    stim_state_t      state;
    logic [CNT_W-1:0] seg_cnt;
    logic [CNT_W-1:0] low_len_q;
    logic [CNT_W-1:0] high_len_q;
    logic [NUM_W-1:0] num_q;
    logic [NUM_W-1:0] pulse_inc;
    logic             seg_last;
    logic             run_last;
    logic [CNT_W-1:0] start_low_len;
    logic [CNT_W-1:0] next_low_len;
    logic [CNT_W-1:0] next_high_len;

    // Down-counter preload: a length of 0 behaves as 1 cycle.
    function automatic logic [CNT_W-1:0] seg_load(input logic [CNT_W-1:0] len);
        seg_load = (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

    assign seg_last  = (seg_cnt == '0);
    assign pulse_inc = pulse_cnt + NUM_W'(1);
    assign run_last  = (pulse_inc == num_q);

`ifdef NOR_STIM_LFSR_EN
    logic              random_q;
    logic              lfsr_load;
    logic              lfsr_adv;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic [LFSR_W-1:0] lfsr_state_unused;

    assign lfsr_load = (state == IDLE) && start;
    assign lfsr_adv  = random_q && seg_last &&
                       ((state == LOW) || ((state == HIGH) && !run_last));

    nor_stim_lfsr u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (lfsr_load),
        .advance   (lfsr_adv),
        .seed      (cfg_seed),
        .state     (lfsr_state_unused),
        .state_nxt (lfsr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            random_q <= 1'b0;
        end else if ((state == IDLE) && start) begin
            random_q <= cfg_random;
        end
    end

    assign start_low_len = cfg_random ? lfsr_nxt[CNT_W-1:0] : cfg_low_len;
    assign next_low_len  = random_q   ? lfsr_nxt[CNT_W-1:0] : low_len_q;
    assign next_high_len = random_q   ? lfsr_nxt[CNT_W-1:0] : high_len_q;
`else
    logic unused_cfg;
    assign unused_cfg    = ^{cfg_random, cfg_seed};
    assign start_low_len = cfg_low_len;
    assign next_low_len  = low_len_q;
    assign next_high_len = high_len_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            seg_cnt    <= '0;
            low_len_q  <= '0;
            high_len_q <= '0;
            num_q      <= '0;
            pulse_cnt  <= '0;
            stim_out   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        low_len_q  <= cfg_low_len;
                        high_len_q <= cfg_high_len;
                        num_q      <= cfg_num;
                        pulse_cnt  <= '0;
                        if (cfg_num == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= LOW;
                            busy    <= 1'b1;
                            seg_cnt <= seg_load(start_low_len);
                        end
                    end
                end
                LOW: begin
                    if (seg_last) begin
                        state    <= HIGH;
                        stim_out <= 1'b1;
                        seg_cnt  <= seg_load(next_high_len);
                    end else begin
                        seg_cnt <= seg_cnt - CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (seg_last) begin
                        pulse_cnt <= pulse_inc;
                        stim_out  <= 1'b0;
                        if (run_last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state   <= LOW;
                            seg_cnt <= seg_load(next_low_len);
                        end
                    end else begin
                        seg_cnt <= seg_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nor_chain_stimulus_gen.sv
// Scoreboard bench for nor_chain_stimulus_gen: each run queues its expected stim_out waveform
// and final pulse count; a monitor checks every cycle from start until the expected done cycle.
module tb_nor_chain_stimulus_gen;

    localparam int CNT_W = 8;
    localparam int NUM_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] cfg_low_len = '0;
    logic [CNT_W-1:0] cfg_high_len = '0;
    logic [NUM_W-1:0] cfg_num = '0;
    logic             cfg_random = 1'b0;
    logic [15:0]      cfg_seed = '0;
    logic             stim_out;
    logic             busy;
    logic             done;
    logic [NUM_W-1:0] pulse_cnt;

    int checks = 0;
    int errors = 0;

    string wave_q[$];
    int    pcnt_q[$];

    always #5 clk = ~clk;

    nor_chain_stimulus_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_low_len  (cfg_low_len),
        .cfg_high_len (cfg_high_len),
        .cfg_num      (cfg_num),
        .cfg_random   (cfg_random),
        .cfg_seed     (cfg_seed),
        .stim_out     (stim_out),
        .busy         (busy),
        .done         (done),
        .pulse_cnt    (pulse_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Waveform string: one char per cycle t1..t_done; the last char is the DONE cycle.
    task automatic issue(input int lo, input int hi, input int num, input bit rnd,
                         input logic [15:0] seed, input string wave, input int pc,
                         input bit expect_run);
        @(posedge clk);
        #1;
        cfg_low_len  = CNT_W'(lo);
        cfg_high_len = CNT_W'(hi);
        cfg_num      = NUM_W'(num);
        cfg_random   = rnd;
        cfg_seed     = seed;
        start        = 1'b1;
        if (expect_run) begin
            wave_q.push_back(wave);
            pcnt_q.push_back(pc);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (wave_q.size() > 0 && k < 5000) begin
            @(posedge clk);
            k++;
        end
        if (wave_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d runs pending, expected 0", wave_q.size());
            wave_q.delete();
            pcnt_q.delete();
        end
    endtask

    function automatic string rep(input string c, input int n);
        string s = "";
        for (int i = 0; i < n; i++) s = {s, c};
        return s;
    endfunction

    initial begin : monitor
        bit    active = 1'b0;
        int    idx = 0;
        int    n = 0;
        string w = "";
        forever begin
            @(negedge clk);
            if (active) begin
                idx++;
                n = w.len();
                check("stim_out", 32'(stim_out), 32'((idx <= n && w[idx-1] == "1") ? 1 : 0));
                check("busy", 32'(busy), 32'(idx < n));
                check("done", 32'(done), 32'(idx == n));
                if (idx >= n) begin
                    check("pulse_cnt", 32'(pulse_cnt), 32'(pcnt_q[0]));
                    void'(wave_q.pop_front());
                    void'(pcnt_q.pop_front());
                    active = 1'b0;
                end
            end else if (start && wave_q.size() > 0) begin
                active = 1'b1;
                idx    = 0;
                w      = wave_q[0];
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);
        #2;
        check("rst_stim_out", 32'(stim_out), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_pulse_cnt", 32'(pulse_cnt), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        issue(3, 2, 2, 1'b0, 16'h0, "00011000110", 2, 1'b1);
        drain();

        issue(5, 5, 0, 1'b0, 16'h0, "0", 0, 1'b1);
        drain();

        issue(0, 0, 3, 1'b0, 16'h0, "0101010", 3, 1'b1);
        drain();

        // Start and cfg disturbed at t5 of a run must not alter it.
        issue(3, 2, 2, 1'b0, 16'h0, "00011000110", 2, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        start        = 1'b1;
        cfg_low_len  = 8'd9;
        cfg_high_len = 8'd7;
        cfg_num      = 16'd5;
        cfg_random   = 1'b1;
        cfg_seed     = 16'h1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        issue(1, 4, 1, 1'b0, 16'h0, "011110", 1, 1'b1);
        drain();

        issue(255, 1, 1, 1'b0, 16'h0, {rep("0", 255), "10"}, 1, 1'b1);
        drain();

        // Asynchronous reset in the second HIGH segment (t9).
        issue(3, 2, 2, 1'b0, 16'h0, "", 0, 1'b0);
        repeat (8) @(posedge clk);
        #2;
        check("pre_rst_stim_out", 32'(stim_out), 32'(1));
        check("pre_rst_pulse_cnt", 32'(pulse_cnt), 32'(1));
        rst_n = 1'b0;
        #1;
        check("async_rst_stim_out", 32'(stim_out), 32'(0));
        check("async_rst_busy", 32'(busy), 32'(0));
        check("async_rst_done", 32'(done), 32'(0));
        check("async_rst_pulse_cnt", 32'(pulse_cnt), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_after_rst", 32'({stim_out, busy, done}), 32'(0));
        end

        issue(2, 1, 1, 1'b0, 16'h0, "0010", 1, 1'b1);
        drain();

`ifdef NOR_STIM_LFSR_EN
        // Seed 0x00FF: first LFSR steps give 0xB47F then 0xEE3F -> LOW 127, HIGH 63.
        issue(0, 0, 1, 1'b1, 16'h00FF, {rep("0", 127), rep("1", 63), "0"}, 1, 1'b1);
        drain();
`else
        issue(3, 2, 1, 1'b1, 16'h00FF, "000110", 1, 1'b1);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
